// File: rtl/seq_divider_8by4_pkg.sv
// Shared constants and state encoding for the sequential 8-by-4 restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_8by4_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Width of the iteration counter for the default dividend width
  localparam int ITER_CNT_W = $clog2(DIVIDEND_W_DEF);

  // Quotient reported when the divisor is zero
  localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_8by4_div_restoring_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
module div_restoring_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  // One extra bit above the partial remainder holds the borrow of the trial subtraction
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  assign shifted = {pr, din};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[DIVISOR_W+1];
  assign pr_next = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider_8by4.sv
// Iterative restoring divider, unsigned DIVIDEND_W / DIVISOR_W, one quotient bit per clock MSB first.
// Latency: out_valid DIVIDEND_W cycles after acceptance (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready low from acceptance until the cycle after the output handshake.
module seq_divider_8by4
  import seq_divider_8by4_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [DIVISOR_W:0]   pr;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom
  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0] dvs;
  // A zero divisor spends one pass through RUN so its result appears one cycle after acceptance
  logic                 dbz_pend;

  logic [DIVISOR_W:0]   pr_next;
  logic                 q_bit;

  div_restoring_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr      (pr),
    .din     (work[DIVIDEND_W-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      pr          <= '0;
      work        <= '0;
      dvs         <= '0;
      dbz_pend    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            work        <= dividend;
            dvs         <= divisor;
            pr          <= '0;
            state       <= ST_RUN;
            if (divisor == '0) begin
              cnt      <= '0;
              dbz_pend <= 1'b1;
            end else begin
              cnt      <= CNT_W'(DIVIDEND_W - 1);
              dbz_pend <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (!dbz_pend) begin
            work <= {work[DIVIDEND_W-2:0], q_bit};
            pr   <= pr_next;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            if (dbz_pend) begin
              quotient    <= {DIVIDEND_W{1'b1}};
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= {work[DIVIDEND_W-2:0], q_bit};
              remainder   <= pr_next[DIVISOR_W-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Scoreboard bench for seq_divider_8by4: directed vectors, backpressure, mid-run reset, random regression.
// Latency: checks out_valid rise relative to the acceptance edge.
// Backpressure: drives out_ready low/random and checks results stay stable while held.
module tb_seq_divider_8by4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    time        tacc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ov_seen = 0;

  seq_divider_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks latency on the rising out_valid, result every cycle it is held, pops on handshake
  always @(negedge clk) begin
    if (rst) begin
      ov_seen = 0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at t=%0t", $time);
      end else begin
        if (!ov_seen) begin
          chk("latency", int'(($time - 5 - sbq[0].tacc) / 10), sbq[0].lat);
          ov_seen = 1;
        end
        chk("quotient", int'(quotient), int'(sbq[0].q));
        chk("remainder", int'(remainder), int'(sbq[0].r));
        chk("div_by_zero", int'(div_by_zero), int'(sbq[0].z));
        if (out_ready) begin
          void'(sbq.pop_front());
          ov_seen = 0;
        end
      end
    end
  end

  // Issue one operation; caller is positioned just after a rising edge
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input logic ez,
                       input bit push, input bit rnd);
    int   w;
    exp_t e;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles at t=%0t", $time);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    if (push) begin
      e.q    = eq;
      e.r    = er;
      e.z    = ez;
      e.lat  = (b == 4'd0) ? 1 : 8;
      e.tacc = $time;
      sbq.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_div_by_zero"}, int'(div_by_zero), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int ov_cnt;
    logic [7:0] a;
    logic [3:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Directed vectors
    do_op(8'd143, 4'd13, 8'd11,  4'd0, 1'b0, 1, 0);
    do_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 1, 0);
    do_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 1, 0);
    do_op(8'd0,   4'd15, 8'd0,   4'd0, 1'b0, 1, 0);
    do_op(8'd5,   4'd0,  8'hFF,  4'd0, 1'b1, 1, 0);
    do_op(8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 1, 0);
    drain();

    // Backpressure with ignored in_valid and toggling operands during RUN/DONE
    out_ready = 1'b0;
    do_op(8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 1, 0);
    in_valid = 1'b1;
    dividend = 8'd7;
    divisor  = 4'd2;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      dividend = ~dividend;
      divisor  = ~divisor;
      w++;
    end
    chk("bp_out_valid_seen", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after_hs", int'(in_ready), 1);
    chk("bp_out_valid_after_hs", int'(out_valid), 0);
    chk("bp_queue_empty", sbq.size(), 0);

    // Reset in the middle of RUN discards the in-flight result
    do_op(8'd250, 4'd3, 8'd83, 4'd1, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrun_reset");
    rst = 1'b0;
    ov_cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    chk("no_stale_out_valid", ov_cnt, 0);
    do_op(8'd250, 4'd3, 8'd83, 4'd1, 1'b0, 1, 0);
    drain();

    // Random regression with random output stalls
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      if (b == 4'd0)
        do_op(a, b, 8'hFF, 4'd0, 1'b1, 1, 1);
      else
        do_op(a, b, a / {4'd0, b}, 4'(a % {4'd0, b}), 1'b0, 1, 1);
    end
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
